// File: rtl/main_mem_blk.sv
// main_mem_blk: clocked block-transfer main memory, one cache-line read/write per request
// after a fixed access latency, valid/ready request side and a one-cycle response pulse.
module main_mem_blk #(
    parameter int WORD_W  = 32,
    parameter int WPB     = 4,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WORD_W*WPB-1:0] req_wdata,
    input  logic [WPB-1:0]        req_wmask,
    output logic                  resp_valid,
    output logic [WORD_W*WPB-1:0] resp_rdata,
    output logic                  busy
);
    localparam int WA = ADDR_W - 2;
    localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [WA-1:0] LOW = WA'(WPB - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
    typedef logic [DEPTH-1:0][WORD_W-1:0] memT;
    function automatic memT initMem();
        memT m;
        for (int i = 0; i < DEPTH; i++) m[i] = WORD_W'(i);
        return m;
    endfunction
    memT mem = initMem();
    stateT state;
    logic [CNT_W-1:0] cnt;
    logic wrQ;
    logic [WA-1:0] baseQ;
    logic [WPB-1:0] maskQ;
    logic [WORD_W*WPB-1:0] wdataQ, merged;
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    // Block as it will look once the masked write lands; also the response payload.
    always_comb begin
        merged = '0;
        for (int k = 0; k < WPB; k++)
            merged[k*WORD_W +: WORD_W] = (wrQ && maskQ[k]) ? wdataQ[k*WORD_W +: WORD_W] : mem[baseQ | WA'(k)];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            wrQ <= 1'b0;
            baseQ <= '0;
            maskQ <= '0;
            wdataQ <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= state == RESP;
            case (state)
                IDLE: if (req_valid) begin
                    state <= (LATENCY == 1) ? RESP : WAIT;
                    cnt <= CNT_W'(LATENCY - 1);
                    wrQ <= req_write;
                    baseQ <= WA'(req_addr >> 2) & ~LOW;
                    maskQ <= req_wmask;
                    wdataQ <= req_wdata;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    state <= (cnt == CNT_W'(1)) ? RESP : WAIT;
                end
                RESP: begin
                    state <= IDLE;
                    resp_rdata <= merged;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Array has no reset; the rst_n term keeps an abandoned request from landing.
    always_ff @(posedge clk)
        if (state == RESP && wrQ && rst_n)
            for (int k = 0; k < WPB; k++)
                if (maskQ[k]) mem[baseQ | WA'(k)] <= wdataQ[k*WORD_W +: WORD_W];
endmodule

// File: tb/tb_main_mem_blk.sv
// tb_main_mem_blk: directed + randomized checks of two main_mem_blk configurations
// against a word-array reference model.
module tb_main_mem_blk;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;
    logic vA = 0, rA, wA = 0, rvA, bA;
    logic [9:0] aA = '0;
    logic [3:0] mA = '0;
    logic [127:0] wdA = '0, rdA;
    logic vB = 0, rB, wB = 0, rvB, bB;
    logic [10:0] aB = '0;
    logic [7:0] mB = '0;
    logic [255:0] wdB = '0, rdB;
    main_mem_blk dutA (
        .clk(clk), .rst_n(rst_n), .req_valid(vA), .req_ready(rA), .req_write(wA),
        .req_addr(aA), .req_wdata(wdA), .req_wmask(mA), .resp_valid(rvA),
        .resp_rdata(rdA), .busy(bA)
    );
    main_mem_blk #(.WORD_W(32), .WPB(8), .DEPTH(512), .ADDR_W(11), .LATENCY(1)) dutB (
        .clk(clk), .rst_n(rst_n), .req_valid(vB), .req_ready(rB), .req_write(wB),
        .req_addr(aB), .req_wdata(wdB), .req_wmask(mB), .resp_valid(rvB),
        .resp_rdata(rdB), .busy(bB)
    );
    int checks = 0, failures = 0, cyc = 0, lastAcc = 0;
    int unsigned memA[256], memB[512];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // One request on DUT d (0=A: WPB4 LAT4, 1=B: WPB8 LAT1); checks timing and data.
    task automatic xfer(int d, bit wr, int unsigned addr, logic [255:0] wd, logic [7:0] mask,
                        bit hold, bit spaced, string tag);
        int wpb = d ? 8 : 4;
        int lat = d ? 1 : 4;
        int depth = d ? 512 : 256;
        int base, n, acc;
        logic [255:0] exp = '0;
        if (d) begin vB = 1; wB = wr; aB = addr[10:0]; wdB = wd; mB = mask; end
        else begin vA = 1; wA = wr; aA = addr[9:0]; wdA = wd[127:0]; mA = mask[3:0]; end
        n = 0;
        while (!(d ? rB : rA) && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_ready_timeout"}, 256'(n < 20), 256'(1));
        @(posedge clk); #1;
        acc = cyc;
        if (spaced) chk({tag, "_spacing"}, 256'(acc - lastAcc), 256'(lat + 1));
        lastAcc = acc;
        if (!hold) begin if (d) vB = 0; else vA = 0; end
        chk({tag, "_busy"}, {254'b0, d ? rB : rA, d ? bB : bA}, 256'b01);
        base = int'((addr >> 2) % depth) / wpb * wpb;
        for (int k = 0; k < wpb; k++) begin
            if (d) begin
                if (wr && mask[k]) memB[base+k] = wd[k*32 +: 32];
                exp[k*32 +: 32] = memB[base+k];
            end else begin
                if (wr && mask[k]) memA[base+k] = wd[k*32 +: 32];
                exp[k*32 +: 32] = memA[base+k];
            end
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(d ? rvB : rvA) && n < lat + 6);
        chk({tag, "_latency"}, 256'(n), 256'(lat));
        chk({tag, "_resp_ctl"}, {253'b0, d ? rvB : rvA, d ? rB : rA, d ? bB : bA}, 256'b110);
        chk({tag, "_rdata"}, d ? rdB : {128'b0, rdA}, exp);
        if (!hold) begin
            @(posedge clk); #1;
            chk({tag, "_pulse"}, 256'(d ? rvB : rvA), 256'(0));
            chk({tag, "_hold_rdata"}, d ? rdB : {128'b0, rdA}, exp);
        end
    endtask
    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction
    initial begin
        int n;
        for (int i = 0; i < 256; i++) memA[i] = i;
        for (int i = 0; i < 512; i++) memB[i] = i;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_A", {rA, rvA, bA, rdA}, {1'b1, 2'b0, 128'b0});
        chk("reset_B", {rB, rvB, bB, 125'b0}, {1'b1, 2'b0, 125'b0});
        chk("reset_B_rdata", rdB, '0);
        rst_n = 1;
        @(posedge clk); #1;
        xfer(0, 0, 'h000, '0, '0, 0, 0, "t1_read0");
        chk("t1_const", {128'b0, rdA}, {128'b0, 32'd3, 32'd2, 32'd1, 32'd0});
        xfer(0, 1, 'h01C, {128'b0, 32'hD, 32'hC, 32'hB, 32'hA}, 8'hF, 0, 0, "t2_write1");
        xfer(0, 0, 'h010, '0, '0, 0, 0, "t2_read1");
        chk("t2_const", {128'b0, rdA}, {128'b0, 32'hD, 32'hC, 32'hB, 32'hA});
        xfer(0, 0, 'h004, '0, '0, 0, 0, "t2_read0");
        xfer(0, 1, 'h020, {128'b0, 32'hAA, 32'hBB, 32'hCC, 32'hDD}, 8'h5, 0, 0, "t3_write2");
        chk("t3_const", {128'b0, rdA}, {128'b0, 32'd11, 32'hBB, 32'd9, 32'hDD});
        xfer(0, 0, 'h02C, '0, '0, 0, 0, "t3_read2");
        xfer(0, 1, 'h034, rnd(), 8'h0, 0, 0, "t3_nomask");
        for (int j = 0; j < 6; j++)
            xfer(0, j[0], 'h040 + j * 16, rnd(), 8'(j + 3), j < 5, j > 0, "t4_b2b_A");
        // Write accepted, then reset lands two cycles later: the write must vanish.
        vA = 1; wA = 1; aA = 10'h030; wdA = {4{32'hDEAD}}; mA = 4'hF;
        n = 0;
        while (!rA && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        vA = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("t5_async_reset", {rA, rvA, bA, rdA}, {1'b1, 2'b0, 128'b0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            chk("t5_no_resp", 256'(rvA), 256'(0));
        end
        xfer(0, 0, 'h030, '0, '0, 0, 0, "t5_old_data");
        xfer(1, 0, 'h000, '0, '0, 0, 0, "t6_read0");
        xfer(1, 0, 'h7FC, '0, '0, 0, 0, "t6_last");
        chk("t6_last_word", 256'(rdB[255:224]), 256'(511));
        xfer(1, 1, 'h03C, rnd(), 8'hFF, 0, 0, "t6_write1");
        xfer(1, 1, 'h040, rnd(), 8'hA5, 0, 0, "t6_mask");
        xfer(1, 0, 'h05C, '0, '0, 0, 0, "t6_read2");
        for (int j = 0; j < 6; j++)
            xfer(1, j[0], 'h100 + j * 32, rnd(), 8'($urandom), j < 5, j > 0, "t6_b2b_B");
        for (int b = 0; b < 8; b++) begin
            int len = 2 + int'($urandom_range(3));
            for (int j = 0; j < len; j++)
                xfer(b % 2, 1'($urandom), $urandom, rnd(), 8'($urandom), j < len - 1, j > 0, "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
